// File: rtl/neander_x_pkg.sv
// Shared NEANDER-X definitions used by the sequential multiply/divide engine.
package neander_x_pkg;

  // One iteration per operand bit on the 16-bit datapath.
  localparam int MULDIV_ITERS = 16;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/neander_x_muldiv_unit_if.sv
// Request/result bundle between the control FSM (master) and the mul/div
// engine (slave). The ALU reads the result words combinationally.
interface neander_x_muldiv_unit_if
  import neander_x_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITERS
);

  logic             start;
  muldiv_op_e       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mul_product_low;
  logic [WIDTH-1:0] mul_product_high;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, mul_product_low, mul_product_high,
    input  div_quotient, div_remainder, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, mul_product_low, mul_product_high,
    output div_quotient, div_remainder, div_by_zero
  );

endinterface

// File: rtl/neander_x_muldiv_unit.sv
// Sequential unsigned multiply/divide engine: shift-add MUL and restoring
// DIV, one bit per cycle, sharing a single WIDTH+1-bit adder/subtractor.
module neander_x_muldiv_unit
  import neander_x_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITERS
) (
  input  logic                    clk,
  input  logic                    reset,
  neander_x_muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // Control state and captured operands.
  muldiv_state_e    r_state;
  muldiv_op_e       r_op;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;

  // Working pair: {hi, lo} for MUL, {R, Q} for DIV.
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;

  // Registered outputs.
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_prod_lo;
  logic [WIDTH-1:0] r_prod_hi;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  // Datapath wires.
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_add_a;
  logic [WIDTH:0]   w_add_b;
  logic [WIDTH+1:0] w_sum;
  logic             w_div_ok;
  logic [WIDTH:0]   w_hi_acc;
  logic [WIDTH:0]   w_hi_next;
  logic [WIDTH-1:0] w_lo_next;
  logic             w_start_dbz;

  // Shared adder/subtractor and the next value of the working pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_hi_next = r_hi;
    w_lo_next = r_lo;

    // DIV shifts {R, Q} left before the trial subtract. R < b always holds
    // between iterations, so R's top bit is zero and drops out here.
    w_div_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};

    // MUL: hi + b. DIV: shifted R + ~b + 1; the carry out means R >= b.
    w_add_a  = (r_op == MD_MUL) ? r_hi : w_div_shift;
    w_add_b  = (r_op == MD_MUL) ? {1'b0, r_b} : ~{1'b0, r_b};
    w_sum    = {1'b0, w_add_a} + {1'b0, w_add_b}
             + {{(WIDTH+1){1'b0}}, (r_op == MD_DIV)};
    w_div_ok = w_sum[WIDTH+1];

    // MUL accumulate is conditional on the multiplier LSB, then {hi,lo} >> 1.
    w_hi_acc = r_lo[0] ? w_sum[WIDTH:0] : r_hi;

    if (r_op == MD_MUL) begin
      w_hi_next = {1'b0, w_hi_acc[WIDTH:1]};
      w_lo_next = {w_hi_acc[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_next = w_div_ok ? w_sum[WIDTH:0] : w_div_shift;
      w_lo_next = {r_lo[WIDTH-2:0], w_div_ok};
    end
  end

  assign w_start_dbz = (bus.op == MD_DIV) && (bus.b == '0);

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state   <= IDLE;
      r_op      <= MD_MUL;
      r_b       <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_prod_lo <= '0;
      r_prod_hi <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (w_start_dbz) begin
              // Divide by zero completes immediately without iterating.
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_rem   <= bus.a;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_op    <= bus.op;
              r_b     <= bus.b;
              r_cnt   <= '0;
              r_hi    <= '0;
              r_lo    <= bus.a;
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          if (r_cnt == LAST_ITER) begin
            // Only the finished op's result set is updated.
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_op == MD_MUL) begin
              r_prod_lo <= w_lo_next;
              r_prod_hi <= w_hi_next[WIDTH-1:0];
            end else begin
              r_quot <= w_lo_next;
              r_rem  <= w_hi_next[WIDTH-1:0];
              r_dbz  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.mul_product_low  = r_prod_lo;
  assign bus.mul_product_high = r_prod_hi;
  assign bus.div_quotient     = r_quot;
  assign bus.div_remainder    = r_rem;
  assign bus.div_by_zero      = r_dbz;

endmodule

// File: tb/tb_neander_x_muldiv_unit.sv
// Directed bench for neander_x_muldiv_unit: results, latency, divide by zero,
// ignored start while busy, back-to-back issue and mid-operation reset.
module tb_neander_x_muldiv_unit;
  import neander_x_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  neander_x_muldiv_unit_if #(.WIDTH(16)) bus ();

  neander_x_muldiv_unit #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at the current negedge and drop start one cycle later.
  task automatic issue(input muldiv_op_e op, input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count negedges until done is seen; 40 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.mul_product_low !== 16'h0 || bus.mul_product_high !== 16'h0) begin errors++; $display("FAIL reset_prod got %h_%h want 0000_0000", bus.mul_product_high, bus.mul_product_low); end
    checks++; if (bus.div_quotient !== 16'h0 || bus.div_remainder !== 16'h0 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_div got q=%h r=%h z=%b want 0", bus.div_quotient, bus.div_remainder, bus.div_by_zero); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul;
    int lat;
    issue(MD_MUL, 16'hFFFF, 16'hFFFF);
    wait_done(lat);
    checks++; if (bus.mul_product_low !== 16'h0001 || bus.mul_product_high !== 16'hFFFE) begin errors++; $display("FAIL mul_ffff got %h_%h want fffe_0001", bus.mul_product_high, bus.mul_product_low); end
    @(negedge clk);
    issue(MD_MUL, 16'h0000, 16'h1234);
    wait_done(lat);
    checks++; if (bus.mul_product_low !== 16'h0000 || bus.mul_product_high !== 16'h0000) begin errors++; $display("FAIL mul_zero got %h_%h want 0000_0000", bus.mul_product_high, bus.mul_product_low); end
    @(negedge clk);
    issue(MD_MUL, 16'h1234, 16'h5678);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy_after_accept got %b want 1", bus.busy); end
    wait_done(lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL mul_latency got %0d want 16", lat); end
    checks++; if (bus.mul_product_low !== 16'h0060 || bus.mul_product_high !== 16'h0626) begin errors++; $display("FAIL mul_1234x5678 got %h_%h want 0626_0060", bus.mul_product_high, bus.mul_product_low); end
    checks++; if (bus.div_quotient !== 16'h0 || bus.div_remainder !== 16'h0 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL mul_div_untouched got q=%h r=%h z=%b want 0", bus.div_quotient, bus.div_remainder, bus.div_by_zero); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_div;
    int lat;
    issue(MD_DIV, 16'd1000, 16'd7);
    wait_done(lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL div_latency got %0d want 16", lat); end
    checks++; if (bus.div_quotient !== 16'h008E || bus.div_remainder !== 16'h0006 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL div_1000_7 got q=%h r=%h z=%b want 008e 0006 0", bus.div_quotient, bus.div_remainder, bus.div_by_zero); end
    checks++; if (bus.mul_product_low !== 16'h0060 || bus.mul_product_high !== 16'h0626) begin errors++; $display("FAIL div_mul_untouched got %h_%h want 0626_0060", bus.mul_product_high, bus.mul_product_low); end
    @(negedge clk);
    issue(MD_DIV, 16'd5, 16'd9);
    wait_done(lat);
    checks++; if (bus.div_quotient !== 16'h0000 || bus.div_remainder !== 16'h0005) begin errors++; $display("FAIL div_5_9 got q=%h r=%h want 0000 0005", bus.div_quotient, bus.div_remainder); end
    @(negedge clk);
    issue(MD_DIV, 16'hFFFF, 16'd1);
    wait_done(lat);
    checks++; if (bus.div_quotient !== 16'hFFFF || bus.div_remainder !== 16'h0000) begin errors++; $display("FAIL div_ffff_1 got q=%h r=%h want ffff 0000", bus.div_quotient, bus.div_remainder); end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero;
    int lat;
    issue(MD_DIV, 16'h1234, 16'h0000);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dbz_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL dbz_done got %b want 1", bus.done); end
    checks++; if (bus.div_quotient !== 16'hFFFF || bus.div_remainder !== 16'h1234 || bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_result got q=%h r=%h z=%b want ffff 1234 1", bus.div_quotient, bus.div_remainder, bus.div_by_zero); end
    checks++; if (bus.mul_product_low !== 16'h0060 || bus.mul_product_high !== 16'h0626) begin errors++; $display("FAIL dbz_mul_untouched got %h_%h want 0626_0060", bus.mul_product_high, bus.mul_product_low); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dbz_after got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    issue(MD_DIV, 16'd10, 16'd3);
    wait_done(lat);
    checks++; if (bus.div_quotient !== 16'd3 || bus.div_remainder !== 16'd1 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL div_10_3 got q=%h r=%h z=%b want 0003 0001 0", bus.div_quotient, bus.div_remainder, bus.div_by_zero); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat;
    issue(MD_MUL, 16'd3, 16'd5);
    repeat (4) @(negedge clk);
    issue(MD_DIV, 16'd100, 16'd7);
    wait_done(lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL ignore_latency got %0d want 11 after pulse", lat); end
    checks++; if (bus.mul_product_low !== 16'd15 || bus.mul_product_high !== 16'd0) begin errors++; $display("FAIL ignore_product got %h_%h want 0000_000f", bus.mul_product_high, bus.mul_product_low); end
    checks++; if (bus.div_quotient !== 16'd3 || bus.div_remainder !== 16'd1) begin errors++; $display("FAIL ignore_div_untouched got q=%h r=%h want 0003 0001", bus.div_quotient, bus.div_remainder); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(MD_MUL, 16'd7, 16'd9);
    wait_done(lat);
    checks++; if (bus.mul_product_low !== 16'd63) begin errors++; $display("FAIL b2b_first got %h want 003f", bus.mul_product_low); end
    issue(MD_DIV, 16'd100, 16'd7);
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_no_gap got busy=%b done=%b want 1 0", bus.busy, bus.done); end
    wait_done(lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL b2b_latency got %0d want 16", lat); end
    checks++; if (bus.div_quotient !== 16'd14 || bus.div_remainder !== 16'd2 || bus.mul_product_low !== 16'd63) begin errors++; $display("FAIL b2b_result got q=%h r=%h p=%h want 000e 0002 003f", bus.div_quotient, bus.div_remainder, bus.mul_product_low); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    issue(MD_MUL, 16'h1234, 16'h5678);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.mul_product_low !== 16'h0 || bus.mul_product_high !== 16'h0 || bus.div_quotient !== 16'h0 || bus.div_remainder !== 16'h0 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL midreset_outputs got %h_%h q=%h r=%h z=%b want 0", bus.mul_product_high, bus.mul_product_low, bus.div_quotient, bus.div_remainder, bus.div_by_zero); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
    issue(MD_DIV, 16'd1000, 16'd7);
    wait_done(lat);
    checks++; if (lat != 16 || bus.div_quotient !== 16'h008E || bus.div_remainder !== 16'h0006) begin errors++; $display("FAIL midreset_recover got lat=%0d q=%h r=%h want 16 008e 0006", lat, bus.div_quotient, bus.div_remainder); end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = MD_MUL;
    bus.a     = '0;
    bus.b     = '0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
